input_arbiter_pkt_stats: RTL and testbench



---
 rtl/input_arbiter_pkg.sv | 23 ++
 rtl/pkt_stats_counter.sv | 51 +++++
 rtl/input_arbiter_pkt_stats.sv | 146 ++++++++++++++
 tb/tb_input_arbiter_pkt_stats.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_arbiter_pkg.sv
// Shared definitions for the input arbiter statistics slice: per-stream
// packet FSM encoding, default counter width and the EOP popcount helper.
package input_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    localparam int CNT_WIDTH_DEF = 32;
    localparam int MAX_PORTS     = 8;

    // Number of set bits in an EOP vector of up to MAX_PORTS streams.
    function automatic logic [3:0] popcount(input logic [MAX_PORTS-1:0] vec);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            n = n + {3'b000, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pkt_stats_counter.sv
// Clear-on-read packet counter. A clear loads the increment arriving in the
// same cycle so no event is lost across a register read.
// Build option: INPUT_ARBITER_PKT_STATS_SATURATE_EN clamps at all-ones
// instead of wrapping.
module pkt_stats_counter
    import input_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int INC_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_p2;

    // Accumulate with either saturation or modulo wrap.
    function automatic logic [CNT_WIDTH-1:0] next_count(
        input logic [CNT_WIDTH-1:0] cur,
        input logic [INC_WIDTH-1:0] step
    );
`ifdef INPUT_ARBITER_PKT_STATS_SATURATE_EN
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cur} + (CNT_WIDTH+1)'(step);
        if (sum[CNT_WIDTH]) begin
            return '1;
        end
        return sum[CNT_WIDTH-1:0];
`else
        return cur + CNT_WIDTH'(step);
`endif
    endfunction

    // ---- stage 2: counter register ----
    // Clear restarts the count from this cycle's increment; otherwise accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p2 <= '0;
        end else if (clear) begin
            cnt_p2 <= CNT_WIDTH'(inc);
        end else begin
            cnt_p2 <= next_count(cnt_p2, inc);
        end
    end

    assign cnt = cnt_p2;

endmodule

// File: rtl/input_arbiter_pkt_stats.sv
// Passive statistics stage for the input arbiter. Snoops NUM_PORTS slave
// streams and the master stream, counts completed packets (2-cycle latency
// from EOP beat to counter) and reports which inputs are mid-packet.
// Build option: INPUT_ARBITER_PKT_STATS_SATURATE_EN (saturating counters).
module input_arbiter_pkt_stats
    import input_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] s_tvalid,
    input  logic [NUM_PORTS-1:0] s_tready,
    input  logic [NUM_PORTS-1:0] s_tlast,
    input  logic                 m_tvalid,
    input  logic                 m_tready,
    input  logic                 m_tlast,
    input  logic                 pktin_clear,
    input  logic                 pktout_clear,
    output logic [CNT_WIDTH-1:0] pktin_cnt,
    output logic [CNT_WIDTH-1:0] pktout_cnt,
    output logic [NUM_PORTS-1:0] in_pkt_mask,
    output logic                 sop_err
);

    localparam int INC_W = $clog2(NUM_PORTS + 1);

    logic [NUM_PORTS-1:0] in_beat_p0;
    logic                 out_beat_p0;
    logic [NUM_PORTS-1:0] in_eop_p1;
    logic                 out_eop_p1;
    logic [MAX_PORTS-1:0] in_eop_pad_p1;
    logic [INC_W-1:0]     in_inc_p1;

    pkt_state_e in_state  [NUM_PORTS];
    pkt_state_e in_next   [NUM_PORTS];
    pkt_state_e out_state;
    pkt_state_e out_next;
    logic       sop_err_q;

    assign in_beat_p0  = s_tvalid & s_tready;
    assign out_beat_p0 = m_tvalid & m_tready;

    // ---- stage 1: register end-of-packet beats ----
    // Capture EOP beats on every input and on the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_eop_p1  <= '0;
            out_eop_p1 <= 1'b0;
        end else begin
            in_eop_p1  <= in_beat_p0 & s_tlast;
            out_eop_p1 <= out_beat_p0 & m_tlast;
        end
    end

    // ---- stage 2: popcount and counter update ----
    // Reduce the input EOP vector to a packet count for this cycle.
    always_comb begin
        in_eop_pad_p1                 = '0;
        in_eop_pad_p1[NUM_PORTS-1:0]  = in_eop_p1;
        in_inc_p1                     = INC_W'(popcount(in_eop_pad_p1));
    end

    pkt_stats_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (INC_W)
    ) u_pktin (
        .clk   (clk),
        .reset (reset),
        .inc   (in_inc_p1),
        .clear (pktin_clear),
        .cnt   (pktin_cnt)
    );

    pkt_stats_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (1)
    ) u_pktout (
        .clk   (clk),
        .reset (reset),
        .inc   (out_eop_p1),
        .clear (pktout_clear),
        .cnt   (pktout_cnt)
    );

    // Per-input packet FSM state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_state[i] <= in_next[i];
            end
        end
    end

    // Per-input next state: a non-last beat opens a packet, an EOP closes it.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_next[i] = in_state[i];
            case (in_state[i])
                IDLE:    if (in_beat_p0[i] && !s_tlast[i]) in_next[i] = IN_PKT;
                IN_PKT:  if (in_beat_p0[i] && s_tlast[i])  in_next[i] = IDLE;
                default: in_next[i] = IDLE;
            endcase
        end
    end

    // Mid-packet mask straight from the registered per-input state.
    always_comb begin
        in_pkt_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_pkt_mask[i] = (in_state[i] == IN_PKT);
        end
    end

    // Output packet FSM state register plus reserved sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_state <= IDLE;
            sop_err_q <= 1'b0;
        end else begin
            out_state <= out_next;
            sop_err_q <= sop_err_q;
        end
    end

    // Output next state follows the same packet framing rules.
    always_comb begin
        out_next = out_state;
        case (out_state)
            IDLE:    if (out_beat_p0 && !m_tlast) out_next = IN_PKT;
            IN_PKT:  if (out_beat_p0 && m_tlast)  out_next = IDLE;
            default: out_next = IDLE;
        endcase
    end

    // Output-side status: sop_err is reserved and never set in this revision.
    always_comb begin
        sop_err = sop_err_q;
    end

endmodule

// File: tb/tb_input_arbiter_pkt_stats.sv
// Bench for input_arbiter_pkt_stats: a full-width instance and a 4-bit
// counter instance share the stimulus so the wrap/saturate edge is reachable.
module tb_input_arbiter_pkt_stats;

    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] s_tvalid, s_tready, s_tlast;
    logic          m_tvalid, m_tready, m_tlast;
    logic          pktin_clear, pktout_clear;

    logic [31:0]   pktin_cnt, pktout_cnt;
    logic [NP-1:0] in_pkt_mask;
    logic          sop_err;
    logic [3:0]    sm_pktin_cnt, sm_pktout_cnt;
    logic [NP-1:0] sm_in_pkt_mask;
    logic          sm_sop_err;

    int n_cmp = 0;
    int n_err = 0;

    longint e_in, e_out, e_sin, e_sout;
    int     p_in, p_out;
    bit     mid [NP];

    input_arbiter_pkt_stats dut (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .pktin_clear(pktin_clear), .pktout_clear(pktout_clear),
        .pktin_cnt(pktin_cnt), .pktout_cnt(pktout_cnt),
        .in_pkt_mask(in_pkt_mask), .sop_err(sop_err)
    );

    input_arbiter_pkt_stats #(.NUM_PORTS(NP), .CNT_WIDTH(4)) dut_sm (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .pktin_clear(pktin_clear), .pktout_clear(pktout_clear),
        .pktin_cnt(sm_pktin_cnt), .pktout_cnt(sm_pktout_cnt),
        .in_pkt_mask(sm_in_pkt_mask), .sop_err(sm_sop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter semantics: clear loads the increment, else add; width w.
    function automatic longint upd(input longint cnt, input int inc, input bit clr, input int w);
        longint lim;
        longint r;
        lim = longint'(1) << w;
        r   = clr ? longint'(inc) : cnt + longint'(inc);
`ifdef INPUT_ARBITER_PKT_STATS_SATURATE_EN
        if (r > lim - 1) r = lim - 1;
`else
        r = r % lim;
`endif
        return r;
    endfunction

    task automatic model_reset();
        e_in = 0; e_out = 0; e_sin = 0; e_sout = 0;
        p_in = 0; p_out = 0;
        for (int i = 0; i < NP; i++) mid[i] = 1'b0;
    endtask

    task automatic check_all();
        logic [NP-1:0] em;
        for (int i = 0; i < NP; i++) em[i] = mid[i];
        check("pktin",     64'(pktin_cnt),      64'(e_in));
        check("pktout",    64'(pktout_cnt),     64'(e_out));
        check("mask",      64'(in_pkt_mask),    64'(em));
        check("sop_err",   64'(sop_err),        64'(0));
        check("sm_pktin",  64'(sm_pktin_cnt),   64'(e_sin));
        check("sm_pktout", 64'(sm_pktout_cnt),  64'(e_sout));
        check("sm_mask",   64'(sm_in_pkt_mask), 64'(em));
    endtask

    task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] r, input logic [NP-1:0] l,
                         input logic mv, input logic mr, input logic ml,
                         input logic pc, input logic oc);
        s_tvalid = v; s_tready = r; s_tlast = l;
        m_tvalid = mv; m_tready = mr; m_tlast = ml;
        pktin_clear = pc; pktout_clear = oc;
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock with the currently driven inputs; model advances, then compare.
    task automatic tick();
        int ne;
        int me;
        bit beat [NP];
        bit last [NP];
        bit pc, oc;
        ne = 0;
        for (int i = 0; i < NP; i++) begin
            beat[i] = s_tvalid[i] && s_tready[i];
            last[i] = s_tlast[i];
            if (beat[i] && last[i]) ne++;
        end
        me = (m_tvalid && m_tready && m_tlast) ? 1 : 0;
        pc = pktin_clear;
        oc = pktout_clear;
        @(posedge clk);
        e_in   = upd(e_in,   p_in,  pc, 32);
        e_sin  = upd(e_sin,  p_in,  pc, 4);
        e_out  = upd(e_out,  p_out, oc, 32);
        e_sout = upd(e_sout, p_out, oc, 4);
        p_in   = ne;
        p_out  = me;
        for (int i = 0; i < NP; i++) if (beat[i]) mid[i] = !last[i];
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;

        // Three-beat packet on port 0
        drive(5'b00001, 5'b00001, 5'b00000, 0, 0, 0, 0, 0); tick();
        check("mask_beat1", 64'(in_pkt_mask), 64'(5'b00001));
        tick();
        check("mask_beat2", 64'(in_pkt_mask), 64'(5'b00001));
        drive(5'b00001, 5'b00001, 5'b00001, 0, 0, 0, 0, 0); tick();
        check("mask_after_eop", 64'(in_pkt_mask), 64'(0));
        check("pktin_lat1", 64'(pktin_cnt), 64'(0));
        idle(); tick();
        check("pktin_lat2", 64'(pktin_cnt), 64'(1));

        // All ports EOP in the same cycle, twice
        drive('0, '0, '0, 0, 0, 0, 1, 0); tick();
        check("pktin_cleared", 64'(pktin_cnt), 64'(0));
        drive('1, '1, '1, 0, 0, 0, 0, 0); tick();
        tick();
        check("pktin_5", 64'(pktin_cnt), 64'(5));
        idle(); tick();
        check("pktin_10", 64'(pktin_cnt), 64'(10));
        tick();

        // tvalid without tready on port 2
        drive(5'b00100, 5'b00000, 5'b00100, 0, 0, 0, 0, 0);
        repeat (10) begin
            tick();
            check("stall_mask2", 64'(in_pkt_mask[2]), 64'(0));
            check("stall_cnt", 64'(pktin_cnt), 64'(10));
        end
        idle(); tick();

        // pktout clear coinciding with an increment
        repeat (8) begin
            drive('0, '0, '0, 1, 1, 1, 0, 0); tick();
        end
        check("pktout_7", 64'(pktout_cnt), 64'(7));
        drive('0, '0, '0, 0, 0, 0, 0, 1); tick();
        check("pktout_clr_inc", 64'(pktout_cnt), 64'(1));
        idle(); tick();

        // Wrap / saturate edge on the 4-bit instance
        drive('0, '0, '0, 0, 0, 0, 1, 0); tick();
        drive(5'b11111, 5'b11111, 5'b11111, 0, 0, 0, 0, 0); tick();
        tick();
        drive(5'b01111, 5'b01111, 5'b01111, 0, 0, 0, 0, 0); tick();
        check("sm_at_14_pending", 64'(sm_pktin_cnt), 64'(10));
        drive(5'b00111, 5'b00111, 5'b00111, 0, 0, 0, 0, 0); tick();
        check("sm_at_14", 64'(sm_pktin_cnt), 64'(14));
        idle(); tick();
        tick();
        check("big_17", 64'(pktin_cnt), 64'(17));
`ifdef INPUT_ARBITER_PKT_STATS_SATURATE_EN
        check("sm_edge", 64'(sm_pktin_cnt), 64'(15));
`else
        check("sm_edge", 64'(sm_pktin_cnt), 64'(1));
`endif

        // Reset while port 1 is mid-packet
        drive('0, '0, '0, 0, 0, 0, 1, 0); tick();
        drive(5'b01111, 5'b01111, 5'b01111, 0, 0, 0, 0, 0); tick();
        idle(); tick();
        tick();
        check("pktin_4", 64'(pktin_cnt), 64'(4));
        drive(5'b00010, 5'b00010, 5'b00000, 0, 0, 0, 0, 0); tick();
        tick();
        check("mid_mask1", 64'(in_pkt_mask), 64'(5'b00010));
        idle();
        #2 reset = 1'b1;
        #1;
        check("rst_pktin",  64'(pktin_cnt),   64'(0));
        check("rst_pktout", 64'(pktout_cnt),  64'(0));
        check("rst_mask",   64'(in_pkt_mask), 64'(0));
        check("rst_sop",    64'(sop_err),     64'(0));
        check("rst_sm_in",  64'(sm_pktin_cnt), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(5'b00010, 5'b00010, 5'b00010, 0, 0, 0, 0, 0); tick();
        check("post_rst_mask", 64'(in_pkt_mask), 64'(0));
        idle(); tick();
        check("post_rst_pktin", 64'(pktin_cnt), 64'(1));

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [NP-1:0] v, r, l;
            v = NP'($urandom);
            r = NP'($urandom) | NP'($urandom);
            l = NP'($urandom) & NP'($urandom);
            drive(v, r, l, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
            tick();
        end
        idle(); tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
